ysyx_axi4_sram: RTL

AXI4 responder (slave) modelling on-chip SRAM on the 64-bit bus driven by the core's bus arbiter. It accepts one outstanding read burst and one outstanding write burst concurrently, performs byte-strobed writes into an internal word array, and returns read data beat-by-beat with ID echo. Addresses outside its window return SLVERR. It serves as the simulation memory target behind `io_master_*`.

---
 rtl/ysyx_axi_pkg.sv | 17 +
 rtl/ysyx_axi_burst_addr.sv | 20 ++
 rtl/ysyx_axi4_sram.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ysyx_axi_pkg.sv
// ysyx_axi_pkg: AXI4 burst/response encodings and FSM state types shared by the SRAM responder
package ysyx_axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef logic [1:0] r_state_t;
    typedef logic [1:0] w_state_t;
    localparam r_state_t R_IDLE = 2'd0;
    localparam r_state_t R_WAIT = 2'd1;
    localparam r_state_t R_DATA = 2'd2;
    localparam w_state_t W_IDLE = 2'd0;
    localparam w_state_t W_DATA = 2'd1;
    localparam w_state_t W_WAIT = 2'd2;
    localparam w_state_t W_RESP = 2'd3;
endpackage

// File: rtl/ysyx_axi_burst_addr.sv
// ysyx_axi_burst_addr: next beat address for FIXED/INCR bursts and per-beat error
// (outside the SRAM window, or an unsupported WRAP/reserved burst type)
module ysyx_axi_burst_addr #(
    parameter int ADDR_W = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE = 32'h8000_0000
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              beat_err
);
    import ysyx_axi_pkg::*;
    localparam logic [ADDR_W-1:0] WIN = ADDR_W'(1) << (DEPTH_LOG2 + 3);
    always_comb begin
        next_addr = (burst == BURST_FIXED) ? addr : addr + (ADDR_W'(1) << size);
        beat_err = ((addr - BASE) >= WIN) || (burst == BURST_WRAP) || (burst == 2'b11);
    end
endmodule

// File: rtl/ysyx_axi4_sram.sv
// ysyx_axi4_sram: AXI4 SRAM responder with one read and one write burst in flight.
// Define YSYX_AXI_SRAM_DELAY_EN to insert LFSR-driven wait states before read data and write response.
module ysyx_axi4_sram #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W = 4,
    parameter int DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);
    import ysyx_axi_pkg::*;
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    r_state_t r_state;
    w_state_t w_state;
    logic [ADDR_W-1:0] r_addr, r_next, w_addr, w_next;
    logic [7:0] r_len, r_cnt, w_len, w_cnt;
    logic [2:0] r_size, w_size;
    logic [1:0] r_burst, w_burst;
    logic r_err, w_beat_err, w_err, w_end, r_load, go;
`ifdef YSYX_AXI_SRAM_DELAY_EN
    logic [19:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 20'd1;
        else lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[18]};
    end
    assign go = lfsr[19];
`else
    assign go = 1'b1;
`endif
    ysyx_axi_burst_addr #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .BASE(BASE)) u_raddr (
        .addr(r_addr), .size(r_size), .burst(r_burst), .next_addr(r_next), .beat_err(r_err)
    );
    ysyx_axi_burst_addr #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .BASE(BASE)) u_waddr (
        .addr(w_addr), .size(w_size), .burst(w_burst), .next_addr(w_next), .beat_err(w_beat_err)
    );
    assign arready = (r_state == R_IDLE) && !rst;
    assign awready = (w_state == W_IDLE) && !rst;
    assign rvalid = r_state == R_DATA;
    assign rlast = rvalid && (r_cnt == r_len);
    assign wready = w_state == W_DATA;
    assign bvalid = w_state == W_RESP;
    assign bresp = w_err ? RESP_SLVERR : RESP_OKAY;
    assign w_end = w_cnt == w_len;
    // r_addr runs one beat ahead: each load fetches the beat about to be presented
    assign r_load = (r_state == R_WAIT && go) || (rvalid && rready && !rlast);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            rid <= '0;
            r_addr <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_size <= '0;
            r_burst <= '0;
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else begin
            if (arvalid && arready) begin
                r_state <= R_WAIT;
                rid <= arid;
                r_addr <= araddr;
                r_len <= arlen;
                r_cnt <= '0;
                r_size <= arsize;
                r_burst <= arburst;
            end
            if (r_state == R_WAIT && go) r_state <= R_DATA;
            if (rvalid && rready) begin
                if (rlast) r_state <= R_IDLE;
                else r_cnt <= r_cnt + 8'd1;
            end
            if (r_load) begin
                rdata <= r_err ? '0 : mem[r_addr[DEPTH_LOG2+2:3]];
                rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
                r_addr <= r_next;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            bid <= '0;
            w_addr <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_size <= '0;
            w_burst <= '0;
            w_err <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                w_state <= W_DATA;
                bid <= awid;
                w_addr <= awaddr;
                w_len <= awlen;
                w_cnt <= '0;
                w_size <= awsize;
                w_burst <= awburst;
                w_err <= 1'b0;
            end
            // the slave's own beat count ends the burst; a misplaced wlast only flags the response
            if (wvalid && wready) begin
                w_err <= w_err || w_beat_err || (wlast != w_end);
                w_addr <= w_next;
                w_cnt <= w_cnt + 8'd1;
                if (w_end) w_state <= W_WAIT;
            end
            if (w_state == W_WAIT && go) w_state <= W_RESP;
            if (bvalid && bready) w_state <= W_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (wvalid && wready && !w_beat_err)
            for (int i = 0; i < DATA_W / 8; i++)
                if (wstrb[i]) mem[w_addr[DEPTH_LOG2+2:3]][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule
